// File: rtl/otn_frame_sequencer.sv
// Map-side OTN line-frame sequencer: walks the 4-row frame, inserts overhead,
// pulls payload over valid/ready, and reserves the row-3 CRC tail slot.
module otn_frame_sequencer #(
   parameter int OH_COLS    = 16,
   parameter int PYLD_COLS  = 1024,
   parameter int ROW_COLS   = 1041,
   parameter int FRAME_ROWS = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_enable,
   input  logic [7:0]  i_pyld_data,
   input  logic        i_pyld_valid,
   output logic        o_pyld_ready,
   output logic [1:0]  o_row_cnt,
   output logic [10:0] o_col_cnt,
   output logic [7:0]  o_frame_data,
   output logic        o_frame_data_valid,
   output logic        o_frame_data_fas,
   output logic [15:0] o_frame_cnt,
   output logic [15:0] o_underrun_cnt,
   output logic        o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OH   = 2'd1,
      ST_PYLD = 2'd2,
      ST_TAIL = 2'd3
   } state_t;

   localparam logic [10:0] LAST_OH_COL   = 11'(OH_COLS - 1);
   localparam logic [10:0] LAST_PYLD_COL = 11'(OH_COLS + PYLD_COLS - 1);
   localparam logic [10:0] TAIL_COL      = 11'(ROW_COLS - 1);
   localparam logic [1:0]  LAST_ROW      = 2'(FRAME_ROWS - 1);

   state_t      state_q, state_d;
   logic [1:0]  row_q, row_d;
   logic [10:0] col_q, col_d;
   logic [1:0]  row_out_q, row_out_d;
   logic [10:0] col_out_q, col_out_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        fas_q, fas_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] underrun_q, underrun_d;
   logic        busy_q, busy_d;

   // Row 0 carries FAS (F6 F6 F6 28 28 28) and MFAS; everything else is zero.
   function automatic logic [7:0] oh_byte(input logic [1:0] row,
                                          input logic [10:0] col,
                                          input logic [7:0] mfas);
      logic [7:0] b;
      b = 8'h00;
      if (row == 2'd0) begin
         if (col <= 11'd2) begin
            b = 8'hF6;
         end else if (col <= 11'd5) begin
            b = 8'h28;
         end else if (col == 11'd6) begin
            b = mfas;
         end else begin
            b = 8'h00;
         end
      end else begin
         b = 8'h00;
      end
      return b;
   endfunction

   // Next-state and next-output logic; output registers hold unless a byte is emitted.
   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      row_out_d   = row_out_q;
      col_out_d   = col_out_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      fas_d       = fas_q;
      frame_cnt_d = frame_cnt_q;
      underrun_d  = underrun_q;

      case (state_q)
         ST_IDLE: begin
            row_d = 2'd0;
            col_d = 11'd0;
            if (i_enable) begin
               state_d = ST_OH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_OH: begin
            row_out_d = row_q;
            col_out_d = col_q;
            data_d    = oh_byte(row_q, col_q, frame_cnt_q[7:0]);
            valid_d   = 1'b1;
            fas_d     = (row_q == 2'd0) && (col_q == 11'd0);
            col_d     = col_q + 11'd1;
            if (col_q == LAST_OH_COL) begin
               state_d = ST_PYLD;
            end else begin
               state_d = ST_OH;
            end
         end
         ST_PYLD: begin
            if (i_pyld_valid) begin
               row_out_d = row_q;
               col_out_d = col_q;
               data_d    = i_pyld_data;
               valid_d   = 1'b1;
               fas_d     = 1'b0;
               col_d     = col_q + 11'd1;
               if (col_q == LAST_PYLD_COL) begin
                  state_d = ST_TAIL;
               end else begin
                  state_d = ST_PYLD;
               end
            end else if (underrun_q != 16'hFFFF) begin
               underrun_d = underrun_q + 16'd1;
            end else begin
               underrun_d = underrun_q;
            end
         end
         ST_TAIL: begin
            // Zero tail byte: CRC slot on the last row, stuff elsewhere.
            row_out_d = row_q;
            col_out_d = TAIL_COL;
            data_d    = 8'h00;
            valid_d   = 1'b1;
            fas_d     = 1'b0;
            col_d     = 11'd0;
            if (row_q == LAST_ROW) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               row_d       = 2'd0;
               if (i_enable) begin
                  state_d = ST_OH;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               row_d   = row_q + 2'd1;
               state_d = ST_OH;
            end
         end
         default: begin
            state_d = ST_IDLE;
            row_d   = 2'd0;
            col_d   = 11'd0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State, pointer and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         row_q       <= 2'd0;
         col_q       <= 11'd0;
         row_out_q   <= 2'd0;
         col_out_q   <= 11'd0;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         fas_q       <= 1'b0;
         frame_cnt_q <= 16'd0;
         underrun_q  <= 16'd0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         row_out_q   <= row_out_d;
         col_out_q   <= col_out_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         fas_q       <= fas_d;
         frame_cnt_q <= frame_cnt_d;
         underrun_q  <= underrun_d;
         busy_q      <= busy_d;
      end
   end

   assign o_pyld_ready       = (state_q == ST_PYLD);
   assign o_row_cnt          = row_out_q;
   assign o_col_cnt          = col_out_q;
   assign o_frame_data       = data_q;
   assign o_frame_data_valid = valid_q;
   assign o_frame_data_fas   = fas_q;
   assign o_frame_cnt        = frame_cnt_q;
   assign o_underrun_cnt     = underrun_q;
   assign o_busy             = busy_q;

endmodule
